// File: rtl/mu0_pkg.sv
// MU0 control shared definitions: sequencer states, opcodes, ALU selects, control bundle.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: none.
//
// Contents:
//   state_t   - FETCH / EXEC / HALT sequencer state
//   OP_*      - 4-bit opcode values found in IR[15:12]
//   ALU_*     - alufs encodings driven to the datapath ALU
//   ctrl_t    - every datapath control line as one packed bundle
package mu0_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_B   = 2'b00;
  localparam logic [1:0] ALU_B1  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_wr;
    logic       asel;
    logic       bsel;
    logic [1:0] alufs;
    logic       acc_ce;
    logic       pc_ce;
    logic       pc_src;
    logic       ir_ce;
    logic       acc_oe;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  // Opcodes whose execute phase is a memory access at IR[11:0].
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STO) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // ALU function used when an ACC-loading opcode completes.
  function automatic logic [1:0] exec_alufs(input logic [3:0] op);
    logic [1:0] fs;
    case (op)
      OP_ADD:  fs = ALU_ADD;
      OP_SUB:  fs = ALU_SUB;
      default: fs = ALU_B;
    endcase
    return fs;
  endfunction

endpackage

// File: rtl/mu0_ctrl_decode.sv
// MU0 control decode: combinational map from sequencer state and inputs to datapath controls.
// Latency: 0 cycles (pure combinational; outputs follow state, ir_op, flags, mem_ack).
// Backpressure: a memory phase holds its request lines and reports no retire until mem_ack.
//
// Ports:
//   state      in   current sequencer state
//   ir_op      in   IR[15:12]
//   acc_z      in   ACC == 0
//   acc_n      in   ACC[15]
//   mem_ack    in   memory completes the current access
//   ctrl       out  datapath control bundle
//   retire     out  an EXEC phase completes this cycle
//   next_state out  state to load on the next rising edge
module mu0_ctrl_decode
  import mu0_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] ir_op,
  input  logic       acc_z,
  input  logic       acc_n,
  input  logic       mem_ack,
  output ctrl_t      ctrl,
  output logic       retire,
  output state_t     next_state
);

  always_comb begin
    ctrl       = '0;
    retire     = 1'b0;
    next_state = state;

    case (state)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        // Loading IR and stepping PC only in the ack cycle keeps wait
        // cycles free of side effects.
        if (mem_ack) begin
          ctrl.ir_ce  = 1'b1;
          ctrl.pc_ce  = 1'b1;
          ctrl.pc_src = 1'b0;
          ctrl.bsel   = 1'b1;
          ctrl.alufs  = ALU_B1;
          next_state  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (is_mem_op(ir_op)) begin
          ctrl.mem_req = 1'b1;
          ctrl.asel    = 1'b1;
          if (ir_op == OP_STO) begin
            ctrl.mem_wr = 1'b1;
            ctrl.acc_oe = 1'b1;
          end
          if (mem_ack) begin
            retire = 1'b1;
            if (ir_op != OP_STO) begin
              ctrl.acc_ce = 1'b1;
              ctrl.bsel   = 1'b0;
              ctrl.alufs  = exec_alufs(ir_op);
            end
          end
        end else begin
          // Everything else finishes in one cycle; mem_ack is ignored here
          // because no request is outstanding.
          retire = 1'b1;
          case (ir_op)
            OP_JMP: begin
              ctrl.pc_ce  = 1'b1;
              ctrl.pc_src = 1'b1;
            end
            OP_JGE: begin
              if (!acc_n) begin
                ctrl.pc_ce  = 1'b1;
                ctrl.pc_src = 1'b1;
              end
            end
            OP_JNE: begin
              if (!acc_z) begin
                ctrl.pc_ce  = 1'b1;
                ctrl.pc_src = 1'b1;
              end
            end
            OP_STP: begin
              ctrl.illegal = 1'b0;
            end
            default: begin
              ctrl.illegal = 1'b1;
            end
          endcase
        end

        if (retire) begin
          next_state = (ir_op == OP_STP) ? ST_HALT : ST_FETCH;
        end
      end

      ST_HALT: begin
        ctrl.halted = 1'b1;
      end

      default: begin
        // Unused encoding: recover by starting a fresh fetch.
        next_state = ST_FETCH;
      end
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control sequencer top: state register, retired-instruction counter, reset gating.
// Latency: 2 cycles per instruction with zero-wait memory (FETCH 1 + EXEC 1), +1 per wait cycle.
// Backpressure: mem_req/mem_wr/asel/acc_oe hold steady until mem_ack; enables fire only on ack.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ir_op, acc_z, acc_n        opcode and accumulator flags from the datapath
//   mem_ack / mem_req, mem_wr  request/acknowledge memory handshake
//   asel, bsel, alufs          address mux, ALU B mux, ALU function
//   acc_ce, pc_ce, pc_src      register loads and PC source
//   ir_ce, acc_oe              IR load, ACC write-data drive
//   halted, illegal            HALT indication, undefined-opcode pulse
//   instr_count                retired instructions, wraps at 2^CNT_W
module mu0_control
  import mu0_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ir_op,
  input  logic             acc_z,
  input  logic             acc_n,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       alufs,
  output logic             acc_ce,
  output logic             pc_ce,
  output logic             pc_src,
  output logic             ir_ce,
  output logic             acc_oe,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;
  logic             retire;
  logic [CNT_W-1:0] cnt;

  mu0_ctrl_decode u_decode (
    .state      (state),
    .ir_op      (ir_op),
    .acc_z      (acc_z),
    .acc_n      (acc_n),
    .mem_ack    (mem_ack),
    .ctrl       (ctrl),
    .retire     (retire),
    .next_state (state_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (retire) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Reset silences every output in the same cycle, which also abandons an
  // access that is mid-wait without waiting for the state register.
  always_comb begin
    ctrl_out = ctrl;
    if (reset) begin
      ctrl_out = '0;
    end
  end

  assign mem_req     = ctrl_out.mem_req;
  assign mem_wr      = ctrl_out.mem_wr;
  assign asel        = ctrl_out.asel;
  assign bsel        = ctrl_out.bsel;
  assign alufs       = ctrl_out.alufs;
  assign acc_ce      = ctrl_out.acc_ce;
  assign pc_ce       = ctrl_out.pc_ce;
  assign pc_src      = ctrl_out.pc_src;
  assign ir_ce       = ctrl_out.ir_ce;
  assign acc_oe      = ctrl_out.acc_oe;
  assign halted      = ctrl_out.halted;
  assign illegal     = ctrl_out.illegal;
  assign instr_count = reset ? '0 : cnt;

endmodule

// File: tb/tb_mu0_control.sv
// Bench for mu0_control: a behavioural MU0 datapath and memory driven by the DUT's
// controls, with an ISA-level reference model that predicts every memory transfer.
module tb_mu0_control;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    ir_op;
  logic          acc_z;
  logic          acc_n;
  logic          mem_ack = 1'b0;
  logic          mem_req, mem_wr, asel, bsel;
  logic [1:0]    alufs;
  logic          acc_ce, pc_ce, pc_src, ir_ce, acc_oe, halted, illegal;
  logic [CW-1:0] instr_count;

  mu0_control #(.CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .ir_op       (ir_op),
    .acc_z       (acc_z),
    .acc_n       (acc_n),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .asel        (asel),
    .bsel        (bsel),
    .alufs       (alufs),
    .acc_ce      (acc_ce),
    .pc_ce       (pc_ce),
    .pc_src      (pc_src),
    .ir_ce       (ir_ce),
    .acc_oe      (acc_oe),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Datapath and memory
  logic [15:0] mem [0:4095];
  logic [15:0] mm  [0:4095];
  logic [11:0] pc;
  logic [15:0] ir;
  logic [15:0] acc;
  logic [11:0] addr;
  logic [13:0] outs;

  assign ir_op = ir[15:12];
  assign acc_z = (acc == 16'h0000);
  assign acc_n = acc[15];
  assign addr  = asel ? ir[11:0] : pc;
  assign outs  = {mem_req, mem_wr, asel, bsel, alufs, acc_ce, pc_ce, pc_src,
                  ir_ce, acc_oe, halted, illegal};

  typedef struct {
    logic        wr;
    logic [11:0] a;
    logic [15:0] d;
  } xfer_t;

  xfer_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    wait_mode = 0;
  bit    spur_en = 1'b0;
  bit    sb_en = 1'b0;
  int    ill_seen = 0;
  int    pcce_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Memory responder and datapath registers
  initial begin : datapath
    int          wcnt;
    int          cur_wait;
    logic        s_reset, s_req, s_wr, s_ack, s_bsel, s_acc_ce, s_pc_ce, s_pc_src, s_ir_ce, s_acc_oe;
    logic [1:0]  s_alufs;
    logic [11:0] s_addr;
    logic [15:0] rdata, bval, alu, ir_old;
    pc = '0; ir = '0; acc = '0; wcnt = 0; cur_wait = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt == 0) cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        if (wcnt >= cur_wait) begin
          mem_ack = 1'b1;
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        mem_ack = spur_en && ($urandom_range(0, 3) == 0);
      end
      #1;
      s_reset = reset; s_req = mem_req; s_wr = mem_wr; s_ack = mem_ack; s_bsel = bsel;
      s_alufs = alufs; s_acc_ce = acc_ce; s_pc_ce = pc_ce; s_pc_src = pc_src;
      s_ir_ce = ir_ce; s_acc_oe = acc_oe; s_addr = addr;
      @(posedge clk);
      #1;
      if (s_reset) begin
        pc = '0; ir = '0; acc = '0;
      end else begin
        rdata  = mem[s_addr];
        ir_old = ir;
        bval   = s_bsel ? {4'h0, pc} : rdata;
        case (s_alufs)
          2'b00:   alu = bval;
          2'b01:   alu = bval + 16'd1;
          2'b10:   alu = acc + bval;
          default: alu = acc - bval;
        endcase
        if (s_req && s_ack && s_wr && s_acc_oe) mem[s_addr] = acc;
        if (s_ir_ce) ir = rdata;
        if (s_pc_ce) pc = s_pc_src ? ir_old[11:0] : alu[11:0];
        if (s_acc_ce) acc = alu;
      end
    end
  end

  // Monitor: pops the expected transfer on every completed access
  initial begin : monitor
    xfer_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_en && !reset) begin
        if (mem_req && mem_ack) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_access", {20'h0, addr}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_wr", {31'h0, mem_wr}, {31'h0, e.wr});
            chk("xfer_addr", {20'h0, addr}, {20'h0, e.a});
            if (e.wr) chk("xfer_wdata", {16'h0, (acc_oe ? acc : 16'h0000)}, {16'h0, e.d});
            else      chk("xfer_rdata", {16'h0, mem[addr]}, {16'h0, e.d});
          end
        end
        if (ir_ce || acc_ce) chk("enable_only_on_ack", {31'h0, mem_req && mem_ack}, 32'h1);
        if (illegal) begin
          ill_seen++;
          chk("illegal_quiet", {27'h0, mem_req, acc_ce, pc_ce, ir_ce, acc_oe}, 32'h0);
        end
        if (pc_ce) pcce_seen++;
      end
    end
  end

  function automatic xfer_t mk(input logic wr, input logic [11:0] a, input logic [15:0] d);
    xfer_t x;
    x.wr = wr; x.a = a; x.d = d;
    return x;
  endfunction

  // Instruction-level reference: predicts transfers, retire count, illegal and PC-load counts
  task automatic model(output int ni, output int nill, output int npc);
    logic [11:0] p, ea;
    logic [15:0] a, i;
    bit          stop;
    p = '0; a = '0; ni = 0; nill = 0; npc = 0; stop = 1'b0;
    for (int k = 0; k < 500 && !stop; k++) begin
      exp_q.push_back(mk(1'b0, p, mm[p]));
      i = mm[p];
      p = p + 12'd1;
      npc++;
      ni++;
      ea = i[11:0];
      case (i[15:12])
        4'h0: begin exp_q.push_back(mk(1'b0, ea, mm[ea])); a = mm[ea]; end
        4'h1: begin exp_q.push_back(mk(1'b1, ea, a)); mm[ea] = a; end
        4'h2: begin exp_q.push_back(mk(1'b0, ea, mm[ea])); a = a + mm[ea]; end
        4'h3: begin exp_q.push_back(mk(1'b0, ea, mm[ea])); a = a - mm[ea]; end
        4'h4: begin p = ea; npc++; end
        4'h5: if (!a[15]) begin p = ea; npc++; end
        4'h6: if (a != 16'h0000) begin p = ea; npc++; end
        4'h7: stop = 1'b1;
        default: nill++;
      endcase
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    spur_en = 1'b0;
    reset = 1'b1;
    tick(2);
    chk("reset_outputs", {18'h0, outs}, 32'h0);
    chk("reset_count", {20'h0, instr_count}, 32'h0);
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 4096; k++) mem[k] = 16'h0000;
  endtask

  // Releases reset, runs to HALT, then checks the run totals
  task automatic run_prog(input int wmode, input bit spur, input bit watch, output int cyc);
    int ni, nill, npc;
    for (int k = 0; k < 4096; k++) mm[k] = mem[k];
    exp_q.delete();
    model(ni, nill, npc);
    wait_mode = wmode;
    spur_en = spur;
    ill_seen = 0;
    pcce_seen = 0;
    sb_en = 1'b1;
    reset = 1'b0;
    cyc = 0;
    if (watch) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        #2;
        chk("fetch_hold_req_wr_asel", {29'h0, mem_req, mem_wr, asel}, 32'h4);
        chk("fetch_ir_ce", {31'h0, ir_ce}, (i == 3) ? 32'h1 : 32'h0);
        chk("fetch_pc_ce", {31'h0, pc_ce}, (i == 3) ? 32'h1 : 32'h0);
      end
    end
    while (!halted && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    chk("halted", {31'h0, halted}, 32'h1);
    chk("instr_count", {20'h0, instr_count}, 32'(ni % (1 << CW)));
    chk("illegal_pulses", 32'(ill_seen), 32'(nill));
    chk("pc_ce_pulses", 32'(pcce_seen), 32'(npc));
    chk("sb_leftover", 32'(exp_q.size()), 32'h0);
    sb_en = 1'b0;
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = 16'h0010;
    mem[1] = 16'h2011;
    mem[2] = 16'h1012;
    mem[3] = 16'h7000;
    mem[12'h010] = 16'h0005;
    mem[12'h011] = 16'h0003;
  endtask

  task automatic gen_prog();
    int          n;
    logic [3:0]  op;
    logic [11:0] ea;
    int          sel;
    n = int'($urandom_range(6, 14));
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0:       mem[12'(256 + k)] = 16'h0000;
        1:       mem[12'(256 + k)] = 16'h8000 | 16'($urandom_range(0, 255));
        2:       mem[12'(256 + k)] = 16'h0001;
        default: mem[12'(256 + k)] = 16'($urandom);
      endcase
    end
    for (int i = 0; i < n - 1; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6) op = 4'(sel);
      else          op = 4'(8 + $urandom_range(0, 7));
      if (op < 4'h4)      ea = 12'(256 + $urandom_range(0, 7));
      else if (op < 4'h7) ea = 12'($urandom_range(i + 1, n - 1));
      else                ea = 12'($urandom);
      mem[12'(i)] = {op, ea};
    end
    mem[12'(n - 1)] = 16'h7000;
  endtask

  initial begin : main
    int          cyc;
    logic [15:0] jp [0:11];

    // Straight-line program, zero-wait memory
    do_reset();
    load_basic();
    run_prog(0, 1'b0, 1'b0, cyc);
    chk("halt_cycle", 32'(cyc), 32'd8);
    chk("sto_result", {16'h0, mem[12'h012]}, 32'h0008);

    // Same program, every access held for 3 wait cycles
    do_reset();
    load_basic();
    run_prog(3, 1'b0, 1'b1, cyc);
    chk("sto_result_wait", {16'h0, mem[12'h012]}, 32'h0008);

    // Conditional jumps and an undefined opcode, random waits and stray acks
    do_reset();
    clear_mem();
    jp = '{16'h0100, 16'h5005, 16'h0101, 16'h6005, 16'h5006, 16'h7000,
           16'h0102, 16'h6009, 16'h1103, 16'hA123, 16'h1104, 16'h7000};
    for (int k = 0; k < 12; k++) mem[k] = jp[k];
    mem[12'h100] = 16'h8000;
    mem[12'h101] = 16'h0000;
    mem[12'h102] = 16'h0001;
    mem[12'h103] = 16'h5555;
    run_prog(-1, 1'b1, 1'b0, cyc);
    chk("jne_skipped_sto", {16'h0, mem[12'h103]}, 32'h5555);
    chk("post_illegal_sto", {16'h0, mem[12'h104]}, 32'h0001);

    // Reset while a store is waiting for its ack
    do_reset();
    clear_mem();
    mem[0] = 16'h4001;
    mem[1] = 16'h1050;
    mem[12'h050] = 16'hBEEF;
    wait_mode = 3;
    reset = 1'b0;
    tick(10);
    chk("sto_waiting", {27'h0, mem_req, mem_wr, acc_oe, asel, mem_ack}, 32'h1E);
    chk("count_before_reset", {20'h0, instr_count}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {18'h0, outs}, 32'h0);
    chk("mid_reset_count", {20'h0, instr_count}, 32'h0);
    tick(2);
    wait_mode = 0;
    reset = 1'b0;
    #1;
    chk("post_reset_fetch", {29'h0, mem_req, mem_wr, asel}, 32'h4);
    chk("post_reset_addr", {20'h0, addr}, 32'h0);
    chk("post_reset_count", {20'h0, instr_count}, 32'h0);
    chk("abandoned_store", {16'h0, mem[12'h050]}, 32'hBEEF);

    // Counter wrap through JMP-to-self
    do_reset();
    clear_mem();
    mem[0] = 16'h4000;
    wait_mode = 0;
    reset = 1'b0;
    tick(2 * ((1 << CW) - 1));
    chk("count_at_max", {20'h0, instr_count}, 32'((1 << CW) - 1));
    tick(2);
    chk("count_wrapped", {20'h0, instr_count}, 32'h0);
    chk("jmp_loop_not_halted", {31'h0, halted}, 32'h0);

    // Random programs with forward-only jumps
    for (int t = 0; t < 25; t++) begin
      do_reset();
      clear_mem();
      gen_prog();
      run_prog(-1, 1'b1, 1'b0, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
